// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Drives the 9-bit single-cycle core: owns the program counter, start/halt
//   sequencing, load wait-states and branch-target resolution through a
//   loadable 16-entry table of signed 8-bit PC offsets.
//
//   Optional feature macro: FETCH_SEQ_WATCHDOG_EN
//     defined   -> WDOG_LIMIT parameter and wdog_trip output exist; a run that
//                  accumulates WDOG_LIMIT counted cycles is forced into HALT.
//     undefined -> execution runs until HALT_CODE is fetched.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset (dominates all inputs)
//   start        pulse; begins execution from PC 0 (honoured in IDLE/HALT)
//   mach_code    current instruction from instr_ROM
//   Branch       decode: instruction is a branch
//   MemtoReg     decode: instruction is a load
//   branch_cond  ALU flag; branch taken when Branch && branch_cond
//   lut_we       branch-offset table write enable
//   lut_waddr    table write index
//   lut_wdata    signed 8-bit PC offset
//   prog_ctr     instruction address to instr_ROM
//   instr_valid  commit strobe (combinational); qualifies RegWrite/MemWrite
//   busy         high in RUN or STALL
//   done         high in HALT
//   cycle_cnt    saturating count of RUN+STALL cycles
//   wdog_trip    (watchdog build only) watchdog forced the halt
module fetch_sequencer #(
    parameter int unsigned   PCW        = 10,
    parameter int unsigned   IW         = 9,
    parameter logic [IW-1:0] HALT_CODE  = IW'(9'h1FF),
    parameter int unsigned   LOAD_STALL = 1,
    parameter int unsigned   CW         = 16
`ifdef FETCH_SEQ_WATCHDOG_EN
    ,
    parameter int unsigned   WDOG_LIMIT = 1000
`endif
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [IW-1:0]  mach_code,
    input  logic           Branch,
    input  logic           MemtoReg,
    input  logic           branch_cond,
    input  logic           lut_we,
    input  logic [3:0]     lut_waddr,
    input  logic [7:0]     lut_wdata,
    output logic [PCW-1:0] prog_ctr,
    output logic           instr_valid,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  cycle_cnt
`ifdef FETCH_SEQ_WATCHDOG_EN
    ,
    output logic           wdog_trip
`endif
);

    localparam int unsigned SCW       = 3;
    localparam int unsigned LW        = 8;
    localparam int unsigned LUT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SCW-1:0] stall_q, stall_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           valid_c;
    logic [LW-1:0]  lut_q [LUT_DEPTH];
    logic [LW-1:0]  br_off;
    logic [PCW-1:0] pc_next;
    logic [CW-1:0]  cnt_inc;
`ifdef FETCH_SEQ_WATCHDOG_EN
    logic           wdog_q, wdog_d;
`endif

    // Branch-offset table: not reset; a same-cycle lookup sees the old entry.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

    // Next sequential PC: sign-extended table offset when taken, else +1 (both wrap).
    always_comb begin
        br_off = lut_q[mach_code[3:0]];
        if (Branch && branch_cond) begin
            pc_next = pc_q + PCW'(signed'(br_off));
        end else begin
            pc_next = pc_q + PCW'(1);
        end
    end

    // Saturating cycle counter increment.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    // Next-state and commit decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        valid_c = 1'b0;
`ifdef FETCH_SEQ_WATCHDOG_EN
        wdog_d  = wdog_q;
`endif

        unique case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (mach_code == HALT_CODE) begin
                    state_d = HALT;
                end else if (MemtoReg && (LOAD_STALL != 0)) begin
                    // Counter holds the STALL cycles remaining after the first one.
                    stall_d = SCW'(LOAD_STALL - 1);
                    state_d = STALL;
                end else begin
                    valid_c = 1'b1;
                    pc_d    = pc_next;
                end
            end
            STALL: begin
                cnt_d = cnt_inc;
                if (stall_q == '0) begin
                    valid_c = 1'b1;
                    pc_d    = pc_next;
                    state_d = RUN;
                end else begin
                    stall_d = stall_q - SCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef FETCH_SEQ_WATCHDOG_EN
        // A fresh start clears the trip flag.
        if (start && (state_q == IDLE || state_q == HALT)) begin
            wdog_d = 1'b0;
        end
        // Limit reached by this cycle's count: abandon the instruction and halt.
        if ((state_q == RUN || state_q == STALL) && (cnt_d >= CW'(WDOG_LIMIT))) begin
            state_d = HALT;
            pc_d    = pc_q;
            stall_d = '0;
            valid_c = 1'b0;
            wdog_d  = 1'b1;
        end
`endif

        busy_d = (state_d == RUN) || (state_d == STALL);
        done_d = (state_d == HALT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            stall_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FETCH_SEQ_WATCHDOG_EN
            wdog_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FETCH_SEQ_WATCHDOG_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    // Reset suppresses any commit in the cycle it is asserted.
    assign instr_valid = valid_c & ~reset;
    assign prog_ctr    = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cycle_cnt   = cnt_q;
`ifdef FETCH_SEQ_WATCHDOG_EN
    assign wdog_trip   = wdog_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer. A combinational ROM
// model (code + decode bits per address) feeds the DUT from prog_ctr.
module tb_fetch_sequencer;

    localparam int unsigned PCW   = 10;
    localparam int unsigned IW    = 9;
    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 1024;
    localparam logic [IW-1:0] NOP  = 9'h010;
    localparam logic [IW-1:0] LOAD = 9'h020;
    localparam logic [IW-1:0] HALT = 9'h1FF;

    logic           clk = 1'b0;
    logic           reset, start, lut_we;
    logic [3:0]     lut_waddr;
    logic [7:0]     lut_wdata;
    logic [IW-1:0]  mach_code;
    logic           Branch, MemtoReg, branch_cond;
    logic [PCW-1:0] prog_ctr;
    logic           instr_valid, busy, done;
    logic [CW-1:0]  cycle_cnt;

    logic [IW-1:0]  rom_code [DEPTH];
    logic           rom_br   [DEPTH];
    logic           rom_ld   [DEPTH];
    logic           rom_cond [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mach_code   = rom_code[prog_ctr];
    assign Branch      = rom_br[prog_ctr];
    assign MemtoReg    = rom_ld[prog_ctr];
    assign branch_cond = rom_cond[prog_ctr];

`ifdef FETCH_SEQ_WATCHDOG_EN
    logic wdog_trip;
`endif

    fetch_sequencer #(
        .PCW(PCW), .IW(IW), .HALT_CODE(HALT), .LOAD_STALL(2), .CW(CW)
`ifdef FETCH_SEQ_WATCHDOG_EN
        , .WDOG_LIMIT(1000)
`endif
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mach_code(mach_code),
        .Branch(Branch), .MemtoReg(MemtoReg), .branch_cond(branch_cond),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .prog_ctr(prog_ctr), .instr_valid(instr_valid), .busy(busy),
        .done(done), .cycle_cnt(cycle_cnt)
`ifdef FETCH_SEQ_WATCHDOG_EN
        , .wdog_trip(wdog_trip)
`endif
    );

`ifdef FETCH_SEQ_WATCHDOG_EN
    logic [PCW-1:0] pc_w;
    logic           valid_w, busy_w, done_w, wdog_w;
    logic [CW-1:0]  cnt_w;
    logic [IW-1:0]  code_w;
    logic           br_w, ld_w, cond_w;
    assign code_w = rom_code[pc_w];
    assign br_w   = rom_br[pc_w];
    assign ld_w   = rom_ld[pc_w];
    assign cond_w = rom_cond[pc_w];

    fetch_sequencer #(
        .PCW(PCW), .IW(IW), .HALT_CODE(HALT), .LOAD_STALL(2), .CW(CW), .WDOG_LIMIT(8)
    ) u_wd (
        .clk(clk), .reset(reset), .start(start), .mach_code(code_w),
        .Branch(br_w), .MemtoReg(ld_w), .branch_cond(cond_w),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .prog_ctr(pc_w), .instr_valid(valid_w), .busy(busy_w),
        .done(done_w), .cycle_cnt(cnt_w), .wdog_trip(wdog_w)
    );
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) begin
            rom_code[i] = NOP;
            rom_br[i]   = 1'b0;
            rom_ld[i]   = 1'b0;
            rom_cond[i] = 1'b0;
        end
    endtask

    task automatic set_branch(input int pc, input logic [3:0] idx, input logic cond);
        rom_code[pc] = {5'b10000, idx};
        rom_br[pc]   = 1'b1;
        rom_cond[pc] = cond;
    endtask

    task automatic write_lut(input logic [3:0] idx, input logic [7:0] val);
        lut_we    = 1'b1;
        lut_waddr = idx;
        lut_wdata = val;
        tick();
        lut_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (prog_ctr !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", prog_ctr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (cycle_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cycle_cnt); end
        // IDLE ignores decode inputs
        tick();
        tick();
        checks++; if (prog_ctr !== 10'd0 || busy !== 1'b0) begin errors++; $display("FAIL idle_hold: pc=%0d busy=%b want 0/0", prog_ctr, busy); end
    endtask

    task automatic test_straight();
        clear_rom();
        rom_code[3] = HALT;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            checks++; if (prog_ctr !== PCW'(i)) begin errors++; $display("FAIL straight_pc[%0d]: got %0d want %0d", i, prog_ctr, i); end
            checks++; if (instr_valid !== 1'(i < 3)) begin errors++; $display("FAIL straight_valid[%0d]: got %b want %b", i, instr_valid, (i < 3)); end
            start = (i == 1);
            tick();
            start = 1'b0;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL straight_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL straight_busy: got %b want 0", busy); end
        checks++; if (cycle_cnt !== 16'd4) begin errors++; $display("FAIL straight_cnt: got %0d want 4", cycle_cnt); end
        tick();
        checks++; if (prog_ctr !== 10'd3 || done !== 1'b1) begin errors++; $display("FAIL halt_hold: pc=%0d done=%b want 3/1", prog_ctr, done); end
        pulse_start();
        checks++; if (prog_ctr !== 10'd0 || done !== 1'b0 || busy !== 1'b1 || cycle_cnt !== 16'd0) begin
            errors++; $display("FAIL restart: pc=%0d done=%b busy=%b cnt=%0d want 0/0/1/0", prog_ctr, done, busy, cycle_cnt);
        end
        for (int i = 0; i < 10 && done !== 1'b1; i++) tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b want 1 within 10 cycles", done); end
    endtask

    task automatic test_load();
        int   exp_pc [6] = '{0, 1, 1, 1, 2, 3};
        logic exp_v  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        clear_rom();
        rom_code[1] = LOAD;
        rom_ld[1]   = 1'b1;
        rom_code[3] = HALT;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            checks++; if (prog_ctr !== PCW'(exp_pc[i]) || instr_valid !== exp_v[i] || busy !== 1'b1) begin
                errors++; $display("FAIL load_trace[%0d]: pc=%0d valid=%b busy=%b want %0d/%b/1", i, prog_ctr, instr_valid, busy, exp_pc[i], exp_v[i]);
            end
            tick();
        end
        checks++; if (done !== 1'b1 || cycle_cnt !== 16'd6) begin errors++; $display("FAIL load_end: done=%b cnt=%0d want 1/6", done, cycle_cnt); end
    endtask

    task automatic test_branch();
        write_lut(4'd5, 8'hFD);
        write_lut(4'd6, 8'h05);
        clear_rom();
        set_branch(10, 4'd5, 1'b1);
        set_branch(11, 4'd6, 1'b1);
        rom_code[16] = HALT;
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        checks++; if (prog_ctr !== 10'd10 || instr_valid !== 1'b1) begin errors++; $display("FAIL br_reach: pc=%0d valid=%b want 10/1", prog_ctr, instr_valid); end
        // Overwrite the entry being looked up; the old offset must win.
        lut_we    = 1'b1;
        lut_waddr = 4'd5;
        lut_wdata = 8'h10;
        tick();
        lut_we    = 1'b0;
        checks++; if (prog_ctr !== 10'd7) begin errors++; $display("FAIL br_taken: pc=%0d want 7", prog_ctr); end
        rom_cond[10] = 1'b0;
        tick(); tick(); tick();
        checks++; if (prog_ctr !== 10'd10) begin errors++; $display("FAIL br_loop: pc=%0d want 10", prog_ctr); end
        tick();
        checks++; if (prog_ctr !== 10'd11) begin errors++; $display("FAIL br_not_taken: pc=%0d want 11", prog_ctr); end
        tick();
        checks++; if (prog_ctr !== 10'd16 || instr_valid !== 1'b0) begin errors++; $display("FAIL br_to_halt: pc=%0d valid=%b want 16/0", prog_ctr, instr_valid); end
        tick();
        checks++; if (done !== 1'b1 || prog_ctr !== 10'd16 || cycle_cnt !== 16'd17) begin
            errors++; $display("FAIL br_done: done=%b pc=%0d cnt=%0d want 1/16/17", done, prog_ctr, cycle_cnt);
        end
    endtask

    task automatic test_wrap();
        int exp_pc [5] = '{0, 1022, 2, 1023, 0};
        write_lut(4'd1, 8'hFE);
        write_lut(4'd2, 8'h04);
        write_lut(4'd3, 8'hFD);
        clear_rom();
        set_branch(0, 4'd1, 1'b1);
        set_branch(1022, 4'd2, 1'b1);
        set_branch(2, 4'd3, 1'b1);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            checks++; if (prog_ctr !== PCW'(exp_pc[i])) begin errors++; $display("FAIL wrap_pc[%0d]: got %0d want %0d", i, prog_ctr, exp_pc[i]); end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        clear_rom();
        rom_code[1] = LOAD;
        rom_ld[1]   = 1'b1;
        rom_code[2] = HALT;
        pulse_start();
        tick();
        tick();
        tick();
        // second STALL cycle: would commit, but reset must dominate
        checks++; if (busy !== 1'b1 || prog_ctr !== 10'd1) begin errors++; $display("FAIL stall_reach: busy=%b pc=%0d want 1/1", busy, prog_ctr); end
        reset = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_gate: got %b want 0", instr_valid); end
        tick();
        reset = 1'b0;
        checks++; if (prog_ctr !== 10'd0 || instr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cycle_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_stall: pc=%0d valid=%b busy=%b done=%b cnt=%0d want 0/0/0/0/0", prog_ctr, instr_valid, busy, done, cycle_cnt);
        end
        // LUT[2]=+4 survives reset
        set_branch(0, 4'd2, 1'b1);
        rom_code[4] = HALT;
        pulse_start();
        checks++; if (prog_ctr !== 10'd0 || instr_valid !== 1'b1) begin errors++; $display("FAIL rst_restart: pc=%0d valid=%b want 0/1", prog_ctr, instr_valid); end
        tick();
        checks++; if (prog_ctr !== 10'd4) begin errors++; $display("FAIL lut_persist: pc=%0d want 4", prog_ctr); end
        for (int i = 0; i < 10 && done !== 1'b1; i++) tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_rerun_done: got %b want 1 within 10 cycles", done); end
    endtask

`ifdef FETCH_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        write_lut(4'd7, 8'h00);
        clear_rom();
        set_branch(0, 4'd7, 1'b1);
        pulse_start();
        for (int i = 0; i < 30 && done_w !== 1'b1; i++) tick();
        checks++; if (done_w !== 1'b1 || wdog_w !== 1'b1) begin errors++; $display("FAIL wdog_halt: done=%b trip=%b want 1/1", done_w, wdog_w); end
        checks++; if (cnt_w !== 16'd8 || pc_w !== 10'd0) begin errors++; $display("FAIL wdog_cnt: cnt=%0d pc=%0d want 8/0", cnt_w, pc_w); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (wdog_w !== 1'b0) begin errors++; $display("FAIL wdog_clear: got %b want 0", wdog_w); end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        lut_we    = 1'b0;
        lut_waddr = 4'd0;
        lut_wdata = 8'd0;
        clear_rom();
        test_reset();
        test_straight();
        test_load();
        test_branch();
        test_wrap();
        test_reset_mid_stall();
`ifdef FETCH_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
